scl_bit_counter_gen2: RTL and testbench

- Parametrised SCL-edge bit counter for the I3C controller datapath. Successor to the fixed 0..20 bit counter.
- Adds:
  - run-time terminal count
  - edge-select mode
  - wrap or saturate mode
  - synchronous preload
  - registered terminal-count pulse and done/busy status
- Driven by the SCL edge strobes from the SCL generator. Consumed by the TX/RX framing FSMs.

---
 rtl/scl_bit_counter_gen2.sv | 185 ++++++++++++++++++
 tb/tb_scl_bit_counter_gen2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scl_bit_counter_gen2.sv
// SCL-edge bit counter for the I3C controller datapath.
// Counts qualifying SCL edges up to a run-time terminal count, then wraps or
// saturates. Supports a synchronous preload and emits a registered
// terminal-count pulse plus done/busy status.
// Optional build macro SCL_BITCNT_DOWN_EN adds i_down for down-counting mode.
module scl_bit_counter_gen2 #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned DEF_TC = 20
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_bitcnt_en,
  input  logic             i_scl_pos_edge,
  input  logic             i_scl_neg_edge,
  input  logic [1:0]       i_edge_sel,
  input  logic [CNT_W-1:0] i_term_cnt,
  input  logic             i_wrap,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
`ifdef SCL_BITCNT_DOWN_EN
  input  logic             i_down,
`endif
  output logic [CNT_W-1:0] o_cnt_bit_count,
  output logic             o_tc_pulse,
  output logic             o_done,
  output logic             o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] DEF_TC_V = CNT_W'(DEF_TC);
  localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] tc_q;
  logic [CNT_W-1:0] tc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_d;
  logic             done_d;
  logic             busy_d;

  logic             qe_c;
  logic             dir_down_c;
  logic [CNT_W-1:0] tc_sel_c;
  logic [CNT_W-1:0] load_clamp_c;
  logic [CNT_W-1:0] target_c;
  logic [CNT_W-1:0] restart_c;
  logic [CNT_W-1:0] step_c;

`ifdef SCL_BITCNT_DOWN_EN
  logic down_q;
  logic down_d;

  assign dir_down_c = down_q;
`else
  assign dir_down_c = 1'b0;
`endif

  // Qualifying edge: simultaneous pos+neg strobes collapse into one event.
  always_comb begin
    qe_c = 1'b0;
    case (i_edge_sel)
      2'b01:   qe_c = i_scl_pos_edge;
      2'b10:   qe_c = i_scl_neg_edge;
      default: qe_c = i_scl_pos_edge | i_scl_neg_edge;
    endcase
  end

  // Terminal-count selection, load clamp and direction-dependent endpoints.
  always_comb begin
    tc_sel_c     = (i_term_cnt == '0) ? DEF_TC_V : i_term_cnt;
    load_clamp_c = (i_load_val > tc_q) ? tc_q : i_load_val;
    target_c     = dir_down_c ? '0   : tc_q;
    restart_c    = dir_down_c ? tc_q : '0;
    step_c       = dir_down_c ? (o_cnt_bit_count - ONE_V)
                              : (o_cnt_bit_count + ONE_V);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    cnt_d   = o_cnt_bit_count;
    pulse_d = 1'b0;
`ifdef SCL_BITCNT_DOWN_EN
    down_d  = down_q;
`endif

    if (!i_bitcnt_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tc_d    = tc_sel_c;
          state_d = ST_COUNT;
`ifdef SCL_BITCNT_DOWN_EN
          down_d  = i_down;
          cnt_d   = i_down ? tc_sel_c : '0;
`else
          cnt_d   = '0;
`endif
        end

        ST_COUNT: begin
          if (i_load) begin
            cnt_d = load_clamp_c;
            if (load_clamp_c == target_c) begin
              pulse_d = 1'b1;
              if (!i_wrap) begin
                state_d = ST_DONE;
              end
            end
          end else if (qe_c) begin
            if (o_cnt_bit_count == target_c) begin
              // At the endpoint only wrap moves the count; a live switch to
              // saturate parks the counter in DONE without a second pulse.
              if (i_wrap) begin
                cnt_d = restart_c;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = step_c;
              if (step_c == target_c) begin
                pulse_d = 1'b1;
                if (!i_wrap) begin
                  state_d = ST_DONE;
                end
              end
            end
          end
        end

        ST_DONE: begin
          cnt_d = o_cnt_bit_count;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and captured configuration registers.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tc_q    <= DEF_TC_V;
`ifdef SCL_BITCNT_DOWN_EN
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
`ifdef SCL_BITCNT_DOWN_EN
      down_q  <= down_d;
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_bit_count <= '0;
      o_tc_pulse      <= 1'b0;
      o_done          <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_cnt_bit_count <= cnt_d;
      o_tc_pulse      <= pulse_d;
      o_done          <= done_d;
      o_busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_scl_bit_counter_gen2.sv
// Scoreboard bench for scl_bit_counter_gen2: driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_scl_bit_counter_gen2;

  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          pos;
  logic          neg;
  logic [1:0]    sel;
  logic [CW-1:0] term;
  logic          wrap;
  logic          load;
  logic [CW-1:0] lval;
`ifdef SCL_BITCNT_DOWN_EN
  logic          down;
`endif
  logic [CW-1:0] cnt;
  logic          pulse;
  logic          done;
  logic          busy;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          pulse;
    logic          done;
    logic          busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  scl_bit_counter_gen2 #(.CNT_W(CW), .DEF_TC(20)) dut (
    .i_sys_clk       (clk),
    .i_rst_n         (rst_n),
    .i_bitcnt_en     (en),
    .i_scl_pos_edge  (pos),
    .i_scl_neg_edge  (neg),
    .i_edge_sel      (sel),
    .i_term_cnt      (term),
    .i_wrap          (wrap),
    .i_load          (load),
    .i_load_val      (lval),
`ifdef SCL_BITCNT_DOWN_EN
    .i_down          (down),
`endif
    .o_cnt_bit_count (cnt),
    .o_tc_pulse      (pulse),
    .o_done          (done),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input exp_t e);
    exp_t a;
    a.cnt   = cnt;
    a.pulse = pulse;
    a.done  = done;
    a.busy  = busy;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got cnt=%0d tc=%b done=%b busy=%b, want cnt=%0d tc=%b done=%b busy=%b",
               nm, a.cnt, a.pulse, a.done, a.busy, e.cnt, e.pulse, e.done, e.busy);
    end
  endtask

  // Monitor: one expected response per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      cmp(n, e);
    end
  end

  // One clock of stimulus; the expected registered response is queued.
  task automatic step(input string nm, input logic p, input logic n, input logic ld,
                      input logic [CW-1:0] lv, input logic [CW-1:0] ec,
                      input logic ep, input logic ed, input logic eb);
    exp_t e;
    pos  = p;
    neg  = n;
    load = ld;
    lval = lv;
    @(posedge clk);
    #1;
    e.cnt   = ec;
    e.pulse = ep;
    e.done  = ed;
    e.busy  = eb;
    exp_q.push_back(e);
    name_q.push_back(nm);
    pos  = 1'b0;
    neg  = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t z;
    z = '0;
    rst_n = 1'b0; en = 1'b0; pos = 1'b0; neg = 1'b0; sel = 2'b00;
    term = '0; wrap = 1'b1; load = 1'b0; lval = '0;
`ifdef SCL_BITCNT_DOWN_EN
    down = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Default config: 0..20 then wrap to 0, 1.
    term = '0; wrap = 1'b1; sel = 2'b00; en = 1'b1;
    step("en_edge_ignored", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 22; i++)
      step("dflt_cnt", 1'(i % 2), 1'((i + 1) % 2), 1'b0, 5'd0,
           CW'(i % 21), (i == 20), 1'b0, 1'b1);
    en = 1'b0;
    step("disable", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // TC=8, saturate, pos-only edges.
    term = 5'd8; wrap = 1'b0; sel = 2'b01; en = 1'b1;
    step("en_tc8", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      step("sat_pos", 1'b1, 1'b0, 1'b0, 5'd0, CW'((j > 8) ? 8 : j),
           (j == 8), (j >= 8), 1'b1);
      step("sat_neg", 1'b0, 1'b1, 1'b0, 5'd0, CW'((j > 8) ? 8 : j),
           1'b0, (j >= 8), 1'b1);
    end
    step("done_ignores_load", 1'b0, 1'b0, 1'b1, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    step("disable_done", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Simultaneous strobes, clamped load with qe, wrap from TC.
    term = '0; wrap = 1'b1; sel = 2'b00; en = 1'b1;
    step("en_tc20", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++)
      step("pre_both", 1'b1, 1'b0, 1'b0, 5'd0, CW'(i), 1'b0, 1'b0, 1'b1);
    step("both_once", 1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    step("load_clamp", 1'b1, 1'b0, 1'b1, 5'd30, 5'd20, 1'b1, 1'b0, 1'b1);
    step("wrap_zero", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("load7", 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    step("en_priority", 1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);

    // Negative-only and reserved edge-select modes.
    sel = 2'b10; en = 1'b1;
    step("en_sel10", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sel10_pos", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sel10_neg", 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1);
    sel = 2'b11;
    step("sel11_pos", 1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1);
    step("sel11_both", 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    step("disable_sel", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Saturating load straight to TC.
    sel = 2'b00; wrap = 1'b0; en = 1'b1;
    step("en_sat20", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("load_sat", 1'b0, 1'b0, 1'b1, 5'd25, 5'd20, 1'b1, 1'b1, 1'b1);
    step("done_hold", 1'b1, 1'b0, 1'b0, 5'd0, 5'd20, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    step("disable_sat", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Drop enable at 11, re-enable with TC=5.
    wrap = 1'b1; en = 1'b1;
    step("en_drop", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++)
      step("to11", 1'b1, 1'b0, 1'b0, 5'd0, CW'(i), 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    step("drop_at11", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    term = 5'd5; en = 1'b1;
    step("en_tc5", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    term = 5'd3;
    for (int i = 1; i <= 7; i++)
      step("tc5_wrap", 1'b0, 1'b1, 1'b0, 5'd0, CW'(i % 6), (i == 5), 1'b0, 1'b1);
    for (int i = 2; i <= 4; i++)
      step("to4", 1'b1, 1'b0, 1'b0, 5'd0, CW'(i), 1'b0, 1'b0, 1'b1);

    // Asynchronous reset at count 4, checked before any clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", z);
    @(posedge clk);
    #1;
    step("reset_hold", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("post_reset_en", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);

`ifdef SCL_BITCNT_DOWN_EN
    en = 1'b0;
    step("disable_dn", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    down = 1'b1; term = 5'd6; wrap = 1'b1; sel = 2'b00; en = 1'b1;
    step("en_down", 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++)
      step("down_cnt", 1'b1, 1'b0, 1'b0, 5'd0, CW'((i <= 6) ? (6 - i) : (13 - i)),
           (i == 6), 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
